// File: rtl/bnn_neuron_array.sv
// bnn_neuron_array: PARALLEL_NEURONS XNOR-popcount neurons sharing one input
// stream. NUM_INPUTS bits are streamed in beats of PARALLEL_INPUTS; each
// completed group yields one activation vector held until the consumer takes it.
// Optional feature macro: NEURON_COUNT_OUT_EN adds the out_count port carrying
// the final per-neuron popcounts alongside out.
module bnn_neuron_array #(
  parameter int unsigned PARALLEL_INPUTS  = 8,
  parameter int unsigned PARALLEL_NEURONS = 4,
  parameter int unsigned NUM_INPUTS       = 20,
  parameter int unsigned THRESHOLD_WIDTH  = 32
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [PARALLEL_INPUTS-1:0]                   inputs,
  input  logic [PARALLEL_NEURONS*PARALLEL_INPUTS-1:0]  weights,
  input  logic [PARALLEL_NEURONS*THRESHOLD_WIDTH-1:0]  threshold,
  input  logic                                         inputs_valid,
  input  logic                                         weights_valid,
  output logic                                         in_ready,
  output logic [PARALLEL_NEURONS-1:0]                  out,
  output logic                                         out_valid,
  input  logic                                         out_ready
`ifdef NEURON_COUNT_OUT_EN
  ,
  output logic [PARALLEL_NEURONS*$clog2(NUM_INPUTS+1)-1:0] out_count
`endif
);

  localparam int unsigned PI         = PARALLEL_INPUTS;
  localparam int unsigned PN         = PARALLEL_NEURONS;
  localparam int unsigned TW         = THRESHOLD_WIDTH;
  localparam int unsigned BEATS      = (NUM_INPUTS + PI - 1) / PI;
  localparam int unsigned CW         = $clog2(NUM_INPUTS + 1);
  localparam int unsigned BW         = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned LAST_LANES = NUM_INPUTS - (BEATS - 1) * PI;
  localparam int unsigned CMPW       = (TW > CW) ? TW : CW;

  logic [BW-1:0] beat_cnt;
  logic          last_beat;
  logic          accept;
  logic [PI-1:0] lane_mask;
  logic [PI-1:0] match [PN];
  logic [CW-1:0] acc   [PN];
  logic [CW-1:0] total [PN];
  logic [PN-1:0] fire;

  assign in_ready  = ~out_valid | out_ready;
  assign accept    = inputs_valid & weights_valid & in_ready;
  assign last_beat = (beat_cnt == BW'(BEATS - 1));

  // Lanes beyond NUM_INPUTS on the ragged final beat never contribute.
  always_comb begin
    lane_mask = '1;
    if (last_beat) begin
      for (int unsigned i = 0; i < PI; i++) begin
        lane_mask[i] = (i < LAST_LANES);
      end
    end
  end

  // Running count plus this beat's XNOR matches, and the threshold decision.
  always_comb begin
    for (int unsigned n = 0; n < PN; n++) begin
      match[n] = ~(inputs ^ weights[n*PI +: PI]) & lane_mask;
      total[n] = acc[n];
      for (int unsigned i = 0; i < PI; i++) begin
        total[n] = total[n] + CW'(match[n][i]);
      end
      fire[n] = (CMPW'(total[n]) >= CMPW'(threshold[n*TW +: TW]));
    end
  end

  // Beat counter, accumulators and the held result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt  <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      for (int unsigned n = 0; n < PN; n++) acc[n] <= '0;
`ifdef NEURON_COUNT_OUT_EN
      out_count <= '0;
`endif
    end else begin
      if (accept && last_beat) begin
        beat_cnt  <= '0;
        out       <= fire;
        out_valid <= 1'b1;
        for (int unsigned n = 0; n < PN; n++) begin
          acc[n] <= '0;
`ifdef NEURON_COUNT_OUT_EN
          out_count[n*CW +: CW] <= total[n];
`endif
        end
      end else begin
        if (accept) begin
          beat_cnt <= beat_cnt + BW'(1);
          for (int unsigned n = 0; n < PN; n++) acc[n] <= total[n];
        end
        if (out_ready) out_valid <= 1'b0;
      end
    end
  end

endmodule
